// File: rtl/fc_pkg.sv
// FC weight fetch: shared FSM encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Imported by fc_weight_fetcher and its beat FIFO.
package fc_pkg;

  // Default geometry: 32-bit weights, 32 PEs per beat, 100 columns per pass.
  localparam int FC_DATA_WIDTH  = 32;
  localparam int FC_ADDR_WIDTH  = 9;
  localparam int FC_PARALLEL_PE = 32;
  localparam int FC_COLUMNS     = 100;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_FETCH = 2'd1,
    FC_DONE  = 2'd2
  } fc_state_t;

  // One FIFO entry holds {last, column, beat data}.
  function automatic int fc_beat_bits(input int dw, input int pe, input int aw);
    return dw * pe + aw + 1;
  endfunction

endpackage

// File: rtl/fc_beat_fifo.sv
// Two-entry beat buffer; the head always sits in slot0 so its output is a plain register.
// Latency: a push is visible at the head one cycle later; a push and a pop may share a cycle.
// Backpressure: holds the head while out_rdy=0; a push into a full buffer is dropped unless a pop frees a slot.
//
// Ports: clk, reset_n (async active-low), in_vld/in_dat (write side),
//        out_vld/out_rdy/out_dat (read side, head of queue), count (0..2 entries).
module fc_beat_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = out_rdy && (count != 2'd0);
  assign push_ok = in_vld && ((count != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_dat;
          else               slot1 <= in_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: new entry lands behind whatever stays.
          if (count == 2'd1) begin
            slot0 <= in_dat;
          end else begin
            slot0 <= slot1;
            slot1 <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_vld = (count != 2'd0);
  assign out_dat = slot0;

endmodule

// File: rtl/fc_weight_fetcher.sv
// Streams one pass of FC weight columns 0..fc_columns-1 from main memory to the PE array.
// Latency: first w_valid two cycles after start; one beat per cycle with w_ready held high.
// Backpressure: w_ready=0 holds the beat; reads stop once the two-entry buffer would overflow.
//
// Ports: clk, reset_n (async active-low); start/busy/done pass control;
//        address_fc/read_en_MM_fc/enable_MM_out_fc/dataMainMemo_fc memory side;
//        w_data/w_valid/w_ready/w_last/w_col PE-array side.
// Optional: define FC_FETCH_STALL_COUNT_EN to add the 32-bit stall_cycles output.
module fc_weight_fetcher
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH     = FC_DATA_WIDTH,
  parameter int ADDR_WIDTH     = FC_ADDR_WIDTH,
  parameter int parallel_fc_PE = FC_PARALLEL_PE,
  parameter int fc_columns     = FC_COLUMNS
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [ADDR_WIDTH-1:0]                address_fc,
  output logic                                 read_en_MM_fc,
  output logic                                 enable_MM_out_fc,
  input  logic [DATA_WIDTH*parallel_fc_PE-1:0] dataMainMemo_fc,
  output logic [DATA_WIDTH*parallel_fc_PE-1:0] w_data,
  output logic                                 w_valid,
  input  logic                                 w_ready,
  output logic                                 w_last,
  output logic [ADDR_WIDTH-1:0]                w_col
`ifdef FC_FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]                          stall_cycles
`endif
);

  localparam int ENTRY_W = fc_beat_bits(DATA_WIDTH, parallel_fc_PE, ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] COLS     = (ADDR_WIDTH+1)'(fc_columns);
  localparam logic [ADDR_WIDTH:0] LAST_COL = (ADDR_WIDTH+1)'(fc_columns - 1);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

  fc_state_t            state;
  logic [ADDR_WIDTH:0]  issue_cnt;
  logic [1:0]           fifo_count;
  logic                 pop;
  logic                 credit_ok;
  logic                 issue;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;

  assign pop = w_valid & w_ready;

  // Read data is captured at the edge that closes its issue cycle, so no read
  // is ever outstanding when the next issue is decided; the occupancy test
  // reduces to "room left after this cycle's pop".
  assign credit_ok = (fifo_count < 2'd2) || pop;
  assign issue     = (state == FC_FETCH) && (issue_cnt < COLS) && credit_ok;

  assign read_en_MM_fc = issue;
  assign address_fc    = issue ? issue_cnt[ADDR_WIDTH-1:0] : '0;
  assign push_entry    = {(issue_cnt == LAST_COL), issue_cnt[ADDR_WIDTH-1:0], dataMainMemo_fc};

  fc_beat_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .in_vld (issue),
    .in_dat (push_entry),
    .out_vld(w_valid),
    .out_rdy(w_ready),
    .out_dat(head_entry),
    .count  (fifo_count)
  );

  assign {w_last, w_col, w_data} = head_entry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= FC_IDLE;
      issue_cnt        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      enable_MM_out_fc <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FC_IDLE: begin
          if (start) begin
            state            <= FC_FETCH;
            issue_cnt        <= '0;
            busy             <= 1'b1;
            enable_MM_out_fc <= 1'b1;
          end
        end
        FC_FETCH: begin
          if (issue) issue_cnt <= issue_cnt + ONE;
          if (pop && w_last) begin
            state            <= FC_DONE;
            busy             <= 1'b0;
            enable_MM_out_fc <= 1'b0;
            done             <= 1'b1;
          end
        end
        FC_DONE: state <= FC_IDLE;
        default: state <= FC_IDLE;
      endcase
    end
  end

`ifdef FC_FETCH_STALL_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if ((state == FC_IDLE) && start) begin
      stall_cycles <= '0;
    end else if ((state == FC_FETCH) && w_valid && !w_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_weight_fetcher.sv
// Bench for fc_weight_fetcher: 100-column pass at 32 PEs plus a 1-column instance at 4 PEs.
// Memory model returns slot k of column a as k*1000+a; a scoreboard tracks reads and beats.
module tb_fc_weight_fetcher;

  localparam int DW   = 32;
  localparam int AW   = 9;
  localparam int PE   = 32;
  localparam int NCOL = 100;
  localparam int PE2  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, start, w_ready;
  logic               busy, done, read_en, enable, w_valid, w_last;
  logic [AW-1:0]      address_fc, w_col;
  logic [DW*PE-1:0]   mem_dat, w_data;

  logic               start2, w_ready2;
  logic               busy2, done2, read_en2, enable2, w_valid2, w_last2;
  logic [AW-1:0]      address2, w_col2;
  logic [DW*PE2-1:0]  mem_dat2, w_data2;

`ifdef FC_FETCH_STALL_COUNT_EN
  logic [31:0] stall_cycles, stall_cycles2;
`endif

  fc_weight_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .parallel_fc_PE(PE), .fc_columns(NCOL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .address_fc(address_fc), .read_en_MM_fc(read_en), .enable_MM_out_fc(enable),
    .dataMainMemo_fc(mem_dat), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_last(w_last), .w_col(w_col)
`ifdef FC_FETCH_STALL_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  fc_weight_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .parallel_fc_PE(PE2), .fc_columns(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .address_fc(address2), .read_en_MM_fc(read_en2), .enable_MM_out_fc(enable2),
    .dataMainMemo_fc(mem_dat2), .w_data(w_data2), .w_valid(w_valid2), .w_ready(w_ready2),
    .w_last(w_last2), .w_col(w_col2)
`ifdef FC_FETCH_STALL_COUNT_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: drives the addressed column at negedge, junk otherwise so that a
  // capture without a matching read shows up as bad data.
  always @(negedge clk) begin
    for (int k = 0; k < PE; k++)
      mem_dat[k*DW +: DW] = read_en ? (k * 1000 + int'(address_fc)) : $urandom;
    for (int k = 0; k < PE2; k++)
      mem_dat2[k*DW +: DW] = read_en2 ? (k * 1000 + int'(address2)) : $urandom;
  end

  // Scoreboard state for the main instance.
  int cyc = 0;
  int reads, beats, dones, lasts, exp_col, first_rd, last_rd;
  logic [63:0]      col5_slot3;
  logic             hold_prev, hold_last;
  logic [AW-1:0]    hold_col;
  logic [DW*PE-1:0] hold_data;
  int reads2 = 0, beats2 = 0, dones2 = 0;

  task automatic clear_model();
    reads = 0; beats = 0; dones = 0; lasts = 0; exp_col = 0;
    first_rd = 0; last_rd = 0; hold_prev = 1'b0; col5_slot3 = '0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_prev) begin
        check("hold_valid", w_valid, 1);
        check("hold_col", w_col, hold_col);
        check("hold_last", w_last, hold_last);
        check("hold_data", w_data == hold_data, 1);
      end
      hold_prev = w_valid && !w_ready;
      hold_col  = w_col;
      hold_last = w_last;
      hold_data = w_data;

      if (w_valid && w_ready) begin
        int bad;
        bit found;
        bad = 0; found = 0;
        for (int k = 0; k < PE; k++)
          if (!found && (w_data[k*DW +: DW] !== 32'(k * 1000 + exp_col))) begin
            bad = k; found = 1;
          end
        check("beat_col", w_col, exp_col);
        check("beat_last", w_last, exp_col == NCOL - 1);
        check($sformatf("beat_data_col%0d_slot%0d", exp_col, bad), w_data[bad*DW +: DW], bad * 1000 + exp_col);
        if (exp_col == 5) col5_slot3 = w_data[3*DW +: DW];
        if (w_last) lasts++;
        exp_col++;
        beats++;
        check("beat_has_read", beats <= reads, 1);
      end

      if (read_en) begin
        check("rd_addr", address_fc, reads);
        if (reads == 0) first_rd = cyc;
        last_rd = cyc;
        reads++;
      end else begin
        check("idle_addr", address_fc, 0);
      end
      check("occupancy_le2", (reads - beats) <= 2, 1);

      if (done) begin
        dones++;
        check("done_not_busy", busy, 0);
      end

      if (w_valid2 && w_ready2) beats2++;
      if (done2) dones2++;
      if (read_en2) reads2++;
    end
  end

  task automatic check_reset(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_read_en"}, read_en, 0);
    check({p, "_enable"}, enable, 0);
    check({p, "_address"}, address_fc, 0);
    check({p, "_w_valid"}, w_valid, 0);
    check({p, "_w_last"}, w_last, 0);
    check({p, "_w_col"}, w_col, 0);
    check({p, "_w_data_zero"}, w_data == '0, 1);
  endtask

  // Called #1 after an edge; returns #1 after the edge that sampled start.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: random ready.
  task automatic run_pass(input int mode, input int bound);
    for (int i = 0; i < bound && dones == 0; i++) begin
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ((i % 4) == 0) || ((i % 4) == 3);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_pass(input string p);
    check({p, "_beats"}, beats, NCOL);
    check({p, "_reads"}, reads, NCOL);
    check({p, "_dones"}, dones, 1);
    check({p, "_lasts"}, lasts, 1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; w_ready = 1'b0;
    start2 = 1'b0; w_ready2 = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate pass.
    clear_model(); w_ready = 1'b1;
    pulse_start();
    check("a_busy", busy, 1);
    check("a_enable", enable, 1);
    check("a_valid_early", w_valid, 0);
    @(posedge clk); #1;
    check("a_first_valid", w_valid, 1);
    check("a_first_col", w_col, 0);
    run_pass(0, 300);
    check_pass("a");
    check("a_rd_span", last_rd - first_rd, NCOL - 1);
    check("a_col5_slot3", col5_slot3, 3005);
    check("a_idle_busy", busy, 0);
    check("a_idle_enable", enable, 0);

    // Ready pattern 1,0,0,1.
    clear_model(); w_ready = 1'b1;
    pulse_start();
    run_pass(1, 800);
    check_pass("b");

    // Random ready.
    clear_model(); w_ready = 1'b1;
    pulse_start();
    run_pass(2, 1500);
    check_pass("c");

    // Ready held low for ten cycles after start.
    clear_model(); w_ready = 1'b0;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    check("d_reads", reads, 2);
    check("d_valid", w_valid, 1);
    check("d_col", w_col, 0);
`ifdef FC_FETCH_STALL_COUNT_EN
    check("d_stall", stall_cycles, 9);
`endif
    run_pass(0, 300);
    check_pass("d");

    // Reset in the middle of a pass, then restart.
    clear_model(); w_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 300 && beats < 40; i++) begin
      @(posedge clk); #1;
    end
    check("e_beats_at_reset", beats, 40);
    reset_n = 1'b0;
    #1;
    check_reset("e_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_model();
    pulse_start();
    @(posedge clk); #1;
    check("e_restart_valid", w_valid, 1);
    check("e_restart_col", w_col, 0);
    run_pass(0, 300);
    check_pass("e");

    // Single-column instance with stray starts in FETCH and DONE.
    reads2 = 0; beats2 = 0; dones2 = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    check("f_busy", busy2, 1);
    @(posedge clk); #1;
    start2 = 1'b0;
    check("f_valid", w_valid2, 1);
    check("f_last", w_last2, 1);
    check("f_col", w_col2, 0);
    check("f_slot3", w_data2[3*DW +: DW], 3000);
    @(posedge clk); #1;
    check("f_done", done2, 1);
    check("f_done_busy", busy2, 0);
    check("f_drained", w_valid2, 0);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("f_done_once", done2, 0);
    repeat (4) @(posedge clk);
    #1;
    check("f_idle_busy", busy2, 0);
    check("f_beats", beats2, 1);
    check("f_reads", reads2, 1);
    check("f_dones", dones2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_weight_fetcher.md
FC_WEIGHT_FETCHER -- requirements
Module: fc_weight_fetcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bits per weight word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning column-address width.
REQ-003 SHALL have parameter parallel_fc_PE, default 32, meaning weight words per beat (one per PE).
REQ-004 SHALL have parameter fc_columns, default 100, meaning beats per fetch pass (1..2^ADDR_WIDTH).
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
  clk  input  1  sole clock, posedge logic
  reset_n  input  1  asynchronous active-low reset
  start  input  1  begin one pass over columns 0..fc_columns-1
  busy  output  1  pass in progress
  done  output  1  one-cycle pulse at end of pass
  address_fc  output  ADDR_WIDTH  column address to weight memory
  read_en_MM_fc  output  1  read request this cycle
  enable_MM_out_fc  output  1  memory bus drive enable
  dataMainMemo_fc  input  DATA_WIDTH*parallel_fc_PE  memory read data, updated at negedge
  w_data  output  DATA_WIDTH*parallel_fc_PE  weight beat to PE array
  w_valid  output  1  w_data valid
  w_ready  input  1  PE array accepts beat
  w_last  output  1  beat is column fc_columns-1
  w_col  output  ADDR_WIDTH  column index of current beat

Function
REQ-006 SHALL implement FSM IDLE -> FETCH (on start) -> DONE (last beat accepted) -> IDLE (next cycle).
REQ-007 SHALL ignore start in FETCH and DONE.
REQ-008 SHALL assert busy in FETCH only; done for exactly the one DONE cycle.
REQ-009 SHALL hold enable_MM_out_fc high in FETCH, low otherwise (memory tri-states its bus).
REQ-010 SHALL issue a read (read_en_MM_fc=1, address_fc=next column) in a FETCH cycle iff issue count < fc_columns and fifo_count + inflight - (w_valid & w_ready) < 2.
REQ-011 SHALL capture dataMainMemo_fc at the posedge following an issue (1-cycle latency) into a 2-entry FIFO tagged with column and last flag; no capture without a matching issue.
REQ-012 SHALL present FIFO head on w_data/w_col/w_last with w_valid=1 whenever FIFO non-empty; beat transfers when w_valid & w_ready.
REQ-013 SHALL hold w_data/w_col/w_last stable while w_valid=1 and w_ready=0.
REQ-014 SHALL sustain one beat per cycle with w_ready held high; first w_valid two cycles after start.
REQ-015 SHALL drive address_fc=0 and read_en_MM_fc=0 when not issuing.
REQ-016 SHALL handle fc_columns=1: single beat with w_last=1, then DONE.
REQ-017 SHALL support simultaneous capture and pop in one cycle without loss or duplication.
REQ-018 SHALL allow the w_ready-to-read_en_MM_fc combinational path (REQ-010); all other outputs registered.

Reset
REQ-019 SHALL, on reset_n low at any time including mid-pass, immediately return to IDLE, empty FIFO, clear counters and inflight.
REQ-020 SHALL drive during reset: busy=0, done=0, read_en_MM_fc=0, enable_MM_out_fc=0, address_fc=0, w_valid=0, w_last=0, w_col=0, w_data=0.

Configuration
REQ-021 SHALL, with FC_FETCH_STALL_COUNT_EN defined, add output stall_cycles (32 bits): counts FETCH cycles with w_valid=1 and w_ready=0, cleared on start and reset, saturating at all-ones.
REQ-022 SHALL, without FC_FETCH_STALL_COUNT_EN, omit the port and counter entirely.

Structure
REQ-023 SHALL place FSM state enum and default DATA_WIDTH/ADDR_WIDTH/parallel_fc_PE/fc_columns constants in shared package fc_pkg.
REQ-024 SHALL implement the 2-entry buffer as sub-module fc_beat_fifo (width-parameterised, count output).

Verification
REQ-025 Start, w_ready=1, fc_columns=100 -> addresses 0..99 on consecutive cycles, 100 beats, w_col 0..99, w_last only on col 99, done pulse once.
REQ-026 w_ready toggling 1,0,0,1 repeat -> no beat lost/duplicated; FIFO never exceeds 2; read_en_MM_fc low while credit exhausted.
REQ-027 w_ready=0 for 10 cycles after start -> exactly 2 reads issued, w_data stable; stall_cycles=9 when macro defined.
REQ-028 Memory model with mem[100*k+a]=k*1000+a -> beat col 5 slot 3 equals 3005.
REQ-029 reset_n low at beat 40 -> all outputs at reset values within that cycle; new start restarts from column 0.
REQ-030 fc_columns=1; start pulsed during FETCH and DONE -> one beat with w_last=1, one done, extra starts ignored.
